// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt request latch.
package irq_pkg;
  localparam int CHANNELS = 8;
  localparam int IDX_W    = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;
endpackage

// File: rtl/irq_request_latch_if.sv
// Bundle of the interrupt lines, encoder-facing outputs and consumer handshake.
interface irq_request_latch_if;
  import irq_pkg::*;

  logic                enable;
  logic [CHANNELS-1:0] irq_in;
  logic [CHANNELS-1:0] level_mode;
  logic [CHANNELS-1:0] mask;
  logic [CHANNELS-1:0] channels;
  logic [CHANNELS-1:0] overflow;
  // Handshake: irq_req acts as valid and ack as ready; a transfer happens on a
  // rising edge where irq_req && ack && channels[ack_idx], after which the
  // channel is in service until a single-cycle eoi releases it.
  logic                irq_req;
  logic                ack;
  logic [IDX_W-1:0]    ack_idx;
  logic                eoi;
  logic                in_service;
  logic [IDX_W-1:0]    in_service_idx;
  irq_state_t          state_dbg;

  modport slave (
    input  enable, irq_in, level_mode, mask, ack, ack_idx, eoi,
    output channels, overflow, irq_req, in_service, in_service_idx, state_dbg
  );

  modport master (
    output enable, irq_in, level_mode, mask, ack, ack_idx, eoi,
    input  channels, overflow, irq_req, in_service, in_service_idx, state_dbg
  );
endinterface

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser followed by a one-cycle-delayed copy for rise detection.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_irq,
  output logic o_s_irq,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_next;
  logic                   r_prev;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      assign w_sync_next = i_irq;
    end else begin : g_chain
      assign w_sync_next = {r_sync[SYNC_STAGES-2:0], i_irq};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= w_sync_next;
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s_irq = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/irq_request_latch.sv
// Captures synchronised interrupt lines into a pending register and runs the
// request/acknowledge/end-of-interrupt handshake for one channel at a time.
module irq_request_latch
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset,
  irq_request_latch_if.slave bus
);
  logic [CHANNELS-1:0] w_s_irq;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_overflow;
  logic [CHANNELS-1:0] w_pending_next;
  logic [CHANNELS-1:0] w_overflow_next;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_channels;
  logic [IDX_W-1:0]    r_isr_idx;
  logic                w_ack_ok;
  irq_state_t          r_state;
  irq_state_t          w_state_next;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_line
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_irq   (bus.irq_in[g]),
        .o_s_irq (w_s_irq[g]),
        .o_rise  (w_rise[g])
      );
    end
  endgenerate

  assign w_channels = r_pending & bus.mask;
  // An ack naming a channel that is not currently serviceable is dropped.
  assign w_ack_ok   = (r_state == REQUEST) && bus.ack && w_channels[bus.ack_idx];

  always_comb begin
    w_clr = '0;
    if (w_ack_ok) w_clr[bus.ack_idx] = 1'b1;
  end

  // Edge channels: a new rise outranks the clear so no edge is lost.
  always_comb begin
    w_pending_next  = r_pending;
    w_overflow_next = r_overflow;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.level_mode[i]) begin
        w_pending_next[i] = w_s_irq[i];
      end else begin
        w_pending_next[i]  = w_rise[i] | (r_pending[i] & ~w_clr[i]);
        w_overflow_next[i] = (w_rise[i] & r_pending[i] & ~w_clr[i]) |
                             (r_overflow[i] & ~w_clr[i]);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.enable && |w_channels) w_state_next = REQUEST;
      REQUEST: begin
        if (w_ack_ok)                              w_state_next = SERVICE;
        else if (!bus.enable || w_channels == '0)  w_state_next = IDLE;
      end
      SERVICE: if (bus.eoi) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_overflow <= '0;
      r_isr_idx  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pending_next;
      r_overflow <= w_overflow_next;
      if (w_ack_ok) r_isr_idx <= bus.ack_idx;
    end
  end

  // Outputs decode from registered state only, so ack/eoi never reach irq_req combinationally.
  assign bus.channels       = w_channels;
  assign bus.overflow       = r_overflow;
  assign bus.irq_req        = (r_state == REQUEST);
  assign bus.in_service     = (r_state == SERVICE);
  assign bus.in_service_idx = r_isr_idx;
  assign bus.state_dbg      = r_state;
endmodule
